// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO write arbiter: widths, depth and FSM encodings.
// No logic here, so there is no latency to speak of.
// Backpressure is not applicable; this file only holds definitions.
package fifo_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int GCNT_W = 8;

  // FSM encodings kept as plain constants so older tools can consume them
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WRITE   = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  // True when one more word still fits, counting a write already in flight.
  // The sum is 5 bits wide so count=DEPTH plus an in-flight strobe cannot wrap.
  function automatic logic has_space(input logic [CNT_W-1:0] count,
                                     input logic             wr_en,
                                     input int               depth);
    logic [4:0] occ;
    occ = {1'b0, count} + {4'd0, wr_en};
    return occ < 5'(depth);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Bundle of requester, FIFO-status and arbiter-result signals.
// Pure wiring, no latency.
// Requesters hold req/data until granted; the arbiter never drops a word.
interface fifo_wr_arb_if #(
  parameter int DATA_W = fifo_pkg::DATA_W
);
  import fifo_pkg::*;

  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic              gnt0;
  logic              gnt1;
  logic [CNT_W-1:0]  fifo_data_count;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_d_in;
  logic [GCNT_W-1:0] gnt_cnt0;
  logic [GCNT_W-1:0] gnt_cnt1;
  logic              busy;

  // Requester/FIFO side
  modport master (
    output req0, req1, d0, d1, fifo_data_count,
    input  gnt0, gnt1, fifo_wr_en, fifo_d_in, gnt_cnt0, gnt_cnt1, busy
  );

  // Arbiter side
  modport slave (
    input  req0, req1, d0, d1, fifo_data_count,
    output gnt0, gnt1, fifo_wr_en, fifo_d_in, gnt_cnt0, gnt_cnt1, busy
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select between eligible requesters.
// Combinational, zero latency.
// No backpressure; win_valid simply reports whether anyone is eligible.
module rr_pick2 (
  input  logic elig0,
  input  logic elig1,
  input  logic last_gnt,
  output logic win,
  output logic win_valid
);

  // On a tie the requester that was not granted last wins
  always_comb begin
    win_valid = elig0 | elig1;
    if (elig0 && elig1) begin
      win = ~last_gnt;
    end else begin
      win = elig1;
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Arbitrates two held write requesters into one FIFO write port, round-robin.
// One cycle from eligible request with space to registered gnt/fifo_wr_en.
// Stalls in BLOCKED while the FIFO (plus any in-flight write) is full.
module fifo_wr_arb #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset_n,
  fifo_wr_arb_if.slave  arb
);
  import fifo_pkg::*;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_gnt;
  logic       elig0;
  logic       elig1;
  logic       win;
  logic       win_valid;
  logic       space;
  logic       do_write;

  // A request seen while its grant pulse is high is the word just taken
  assign elig0 = arb.req0 & ~arb.gnt0;
  assign elig1 = arb.req1 & ~arb.gnt1;

  // Reads are ignored, so this errs towards blocking rather than overflowing
  assign space    = has_space(arb.fifo_data_count, arb.fifo_wr_en, DEPTH);
  assign do_write = win_valid & space;

  rr_pick2 u_pick (
    .elig0     (elig0),
    .elig1     (elig1),
    .last_gnt  (last_gnt),
    .win       (win),
    .win_valid (win_valid)
  );

  // Next state depends only on eligibility and space, not the current state
  always_comb begin
    state_nxt = IDLE;
    if (win_valid) begin
      state_nxt = space ? WRITE : BLOCKED;
    end
  end

  // State, grant pulses, write strobe and the held write data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_gnt       <= 1'b1;
      arb.fifo_wr_en <= 1'b0;
      arb.gnt0       <= 1'b0;
      arb.gnt1       <= 1'b0;
      arb.fifo_d_in  <= '0;
    end else begin
      state          <= state_nxt;
      arb.fifo_wr_en <= do_write;
      arb.gnt0       <= do_write & ~win;
      arb.gnt1       <= do_write & win;
      if (do_write) begin
        arb.fifo_d_in <= win ? arb.d1 : arb.d0;
        last_gnt      <= win;
      end
    end
  end

  // Per-requester grant counters, saturating at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb.gnt_cnt0 <= '0;
      arb.gnt_cnt1 <= '0;
    end else begin
      if (arb.gnt0 && (arb.gnt_cnt0 != '1)) begin
        arb.gnt_cnt0 <= arb.gnt_cnt0 + 1'b1;
      end
      if (arb.gnt1 && (arb.gnt_cnt1 != '1)) begin
        arb.gnt_cnt1 <= arb.gnt_cnt1 + 1'b1;
      end
    end
  end

  assign arb.busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: vector table plus hand sequences for saturation
// and asynchronous reset; written words are checked against a queue.
module tb_fifo_wr_arb;

  logic clk;
  logic reset_n;

  fifo_wr_arb_if #(.DATA_W(32)) bus ();

  fifo_wr_arb #(.DATA_W(32), .DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          r0;
    bit          r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  cnt;
    bit          g0;
    bit          g1;
    bit          wr;
    logic [31:0] din;
    bit          busy;
    logic [7:0]  c0;
    logic [7:0]  c1;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] sb_q[$];
  bit          sb_on;
  int          n_vec;
  int          n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst fifo_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
    chk("rst gnt0",       {31'd0, bus.gnt0}, 32'd0);
    chk("rst gnt1",       {31'd0, bus.gnt1}, 32'd0);
    chk("rst fifo_d_in",  bus.fifo_d_in, 32'd0);
    chk("rst gnt_cnt0",   {24'd0, bus.gnt_cnt0}, 32'd0);
    chk("rst gnt_cnt1",   {24'd0, bus.gnt_cnt1}, 32'd0);
    chk("rst busy",       {31'd0, bus.busy}, 32'd0);
    #1;
    reset_n = 1'b1;
  endtask

  // Scoreboard: every observed write must match the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      if (sb_on && reset_n && bus.fifo_wr_en) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb unexpected write: got %0h, expected no write", bus.fifo_d_in);
        end else begin
          chk("sb data", bus.fifo_d_in, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    n_vec   = 0;
    n_bad   = 0;
    sb_on   = 1'b1;
    reset_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.d0   = '0;
    bus.d1   = '0;
    bus.fifo_data_count = '0;

    //          rst r0 r1 d0             d1            cnt  g0 g1 wr din            busy c0 c1
    // single requester, held through its grant cycle
    vt.push_back('{1, 1, 0, 32'hA5A5_0001, 32'h0,        4'd0, 1, 0, 1, 32'hA5A5_0001, 1, 0, 0});
    vt.push_back('{0, 1, 0, 32'hA5A5_0001, 32'h0,        4'd0, 0, 0, 0, 32'hA5A5_0001, 0, 1, 0});
    vt.push_back('{0, 0, 0, 32'h1111_2222, 32'h0,        4'd0, 0, 0, 0, 32'hA5A5_0001, 0, 1, 0});
    // both held: alternate starting with requester 0
    vt.push_back('{1, 1, 1, 32'h10,        32'h11,       4'd0, 1, 0, 1, 32'h10,        1, 0, 0});
    vt.push_back('{0, 1, 1, 32'h10,        32'h11,       4'd0, 0, 1, 1, 32'h11,        1, 1, 0});
    vt.push_back('{0, 1, 1, 32'h10,        32'h11,       4'd0, 1, 0, 1, 32'h10,        1, 1, 1});
    vt.push_back('{0, 1, 1, 32'h10,        32'h11,       4'd0, 0, 1, 1, 32'h11,        1, 2, 1});
    vt.push_back('{0, 0, 0, 32'h10,        32'h11,       4'd0, 0, 0, 0, 32'h11,        0, 2, 2});
    // nearly full with a write in flight -> blocked until count drops
    vt.push_back('{1, 1, 0, 32'h30,        32'h0,        4'd7, 1, 0, 1, 32'h30,        1, 0, 0});
    vt.push_back('{0, 0, 1, 32'h30,        32'h31,       4'd7, 0, 0, 0, 32'h30,        1, 1, 0});
    vt.push_back('{0, 0, 1, 32'h30,        32'h31,       4'd8, 0, 0, 0, 32'h30,        1, 1, 0});
    vt.push_back('{0, 0, 1, 32'h30,        32'h31,       4'd6, 0, 1, 1, 32'h31,        1, 1, 0});
    vt.push_back('{0, 0, 1, 32'h30,        32'h31,       4'd7, 0, 0, 0, 32'h31,        0, 1, 1});
    // full for five cycles, then space returns
    vt.push_back('{1, 1, 0, 32'h40,        32'h0,        4'd8, 0, 0, 0, 32'h0,         1, 0, 0});
    for (int k = 0; k < 4; k++)
      vt.push_back('{0, 1, 0, 32'h40,      32'h0,        4'd8, 0, 0, 0, 32'h0,         1, 0, 0});
    vt.push_back('{0, 1, 0, 32'h40,        32'h0,        4'd3, 1, 0, 1, 32'h40,        1, 0, 0});
    vt.push_back('{0, 0, 0, 32'h40,        32'h0,        4'd3, 0, 0, 0, 32'h40,        0, 1, 0});

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) pulse_reset();
      bus.req0 = vt[i].r0;
      bus.req1 = vt[i].r1;
      bus.d0   = vt[i].d0;
      bus.d1   = vt[i].d1;
      bus.fifo_data_count = vt[i].cnt;
      if (vt[i].wr) sb_q.push_back(vt[i].din);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d gnt0", i),       {31'd0, bus.gnt0}, {31'd0, vt[i].g0});
      chk($sformatf("row%0d gnt1", i),       {31'd0, bus.gnt1}, {31'd0, vt[i].g1});
      chk($sformatf("row%0d fifo_wr_en", i), {31'd0, bus.fifo_wr_en}, {31'd0, vt[i].wr});
      chk($sformatf("row%0d fifo_d_in", i),  bus.fifo_d_in, vt[i].din);
      chk($sformatf("row%0d busy", i),       {31'd0, bus.busy}, {31'd0, vt[i].busy});
      chk($sformatf("row%0d gnt_cnt0", i),   {24'd0, bus.gnt_cnt0}, {24'd0, vt[i].c0});
      chk($sformatf("row%0d gnt_cnt1", i),   {24'd0, bus.gnt_cnt1}, {24'd0, vt[i].c1});
    end
    @(negedge clk);
    chk("sb drained", sb_q.size(), 32'd0);

    // Counter saturation: 300 grants to requester 1
    sb_on = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.fifo_data_count = 4'd0;
    pulse_reset();
    bus.req1 = 1'b1;
    bus.d1   = 32'hBEEF;
    grants = 0;
    for (int c = 0; c < 1000 && grants < 300; c++) begin
      @(posedge clk);
      #1;
      if (bus.gnt1) begin
        grants++;
        if (grants == 100) chk("sat cnt lag", {24'd0, bus.gnt_cnt1}, 32'd99);
      end
    end
    chk("sat grants", grants, 32'd300);
    @(posedge clk);
    #1;
    chk("sat gnt_cnt1", {24'd0, bus.gnt_cnt1}, 32'd255);
    chk("sat gnt_cnt0", {24'd0, bus.gnt_cnt0}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("sat hold", {24'd0, bus.gnt_cnt1}, 32'd255);

    // Asynchronous reset in the middle of a write
    bus.req1 = 1'b0;
    pulse_reset();
    bus.req0 = 1'b1;
    bus.d0   = 32'h33;
    @(posedge clk);
    #1;
    chk("arst pre wr_en", {31'd0, bus.fifo_wr_en}, 32'd1);
    chk("arst pre gnt0",  {31'd0, bus.gnt0}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst wr_en",    {31'd0, bus.fifo_wr_en}, 32'd0);
    chk("arst gnt0",     {31'd0, bus.gnt0}, 32'd0);
    chk("arst fifo_d_in", bus.fifo_d_in, 32'd0);
    chk("arst busy",     {31'd0, bus.busy}, 32'd0);
    bus.req1 = 1'b1;
    bus.d1   = 32'h34;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst regrant gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("arst regrant gnt1", {31'd0, bus.gnt1}, 32'd0);
    chk("arst regrant data", bus.fifo_d_in, 32'h33);
    chk("arst regrant wr",   {31'd0, bus.fifo_wr_en}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, FIFO word width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO capacity in words.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0, req1  input  1 each  requester write request, held with data until granted.
REQ-006 SHALL have ports d0, d1  input  DATA_W each  requester write data.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  registered one-cycle grant pulse.
REQ-008 SHALL have port fifo_data_count  input  4  current FIFO occupancy (0..DEPTH).
REQ-009 SHALL have ports fifo_wr_en, fifo_d_in  output  1 / DATA_W  registered FIFO write strobe and data.
REQ-010 SHALL have ports gnt_cnt0, gnt_cnt1  output  8 each  saturating per-requester grant counters.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, WRITE, BLOCKED; the state register and all outputs are registered.
REQ-013 Eligibility: elig_x = req_x & ~gnt_x; the request seen in the grant cycle is the already-granted word and SHALL be ignored.
REQ-014 Space: space = (fifo_data_count + fifo_wr_en) < DEPTH, with the sum computed at 5 bits; reads are ignored (conservative).
REQ-015 Winner: if one requester is eligible, it wins; if both are eligible, the one not granted last wins (round-robin pointer last_gnt).
REQ-016 When any requester is eligible and space=1, the next cycle SHALL have fifo_wr_en=1, fifo_d_in=winner data, gnt_winner=1, other gnt=0, state=WRITE; last_gnt updates to the winner.
REQ-017 When a requester is eligible and space=0, the next state SHALL be BLOCKED with fifo_wr_en=0 and gnts=0.
REQ-018 When no requester is eligible, the next state SHALL be IDLE with fifo_wr_en=0 and gnts=0.
REQ-019 Transitions: IDLE/WRITE/BLOCKED -> WRITE, BLOCKED or IDLE are chosen solely per REQ-016..018; BLOCKED -> WRITE occurs the cycle after space returns.
REQ-020 Latency: one cycle from eligible request plus space to fifo_wr_en/gnt; at most one write per cycle; a single requester can achieve at most one write every 2 cycles.
REQ-021 fifo_d_in SHALL hold its last value when fifo_wr_en=0.
REQ-022 gnt_cnt_x SHALL increment on each gnt_x pulse and saturate at 255.
REQ-023 The arbiter SHALL never assert fifo_wr_en when the write would exceed DEPTH, so no wr_err can occur from this block.

Reset
REQ-024 When reset_n=0, the block SHALL immediately (asynchronously) set state=IDLE, fifo_wr_en=0, gnt0=gnt1=0, fifo_d_in=0, gnt_cnt0=gnt_cnt1=0, busy=0, and last_gnt=1 (requester 0 wins first tie).
REQ-025 Asserting reset mid-WRITE SHALL cancel the pending strobe; the requester keeps req high and is re-granted after release.

Structure
REQ-026 The shared package fifo_pkg SHALL hold DATA_W, DEPTH, CNT_W=4, and the state encodings IDLE=2'd0, WRITE=2'd1, BLOCKED=2'd2.
REQ-027 The winner selection SHALL be a sub-module rr_pick2 (combinational: elig0, elig1, last_gnt -> win, win_valid); all state stays in fifo_wr_arb.

Verification
REQ-028 Reset, then req0=1, d0=32'hA5A5_0001, fifo_data_count=0 -> the next cycle has gnt0=1, fifo_wr_en=1, fifo_d_in=32'hA5A5_0001, and gnt_cnt0=1 the cycle after.
REQ-029 req0=req1=1 held continuously, count=0 -> grants alternate 0,1,0,1 on consecutive cycles; first grant is to requester 0.
REQ-030 fifo_data_count=7, fifo_wr_en=1 in flight, req1=1 -> state=BLOCKED, no strobe; count drops to 6 -> the next cycle has gnt1=1.
REQ-031 fifo_data_count=8, req0=1 for 5 cycles -> no fifo_wr_en, busy=1, gnt_cnt0 unchanged.
REQ-032 300 grants to requester 1 -> gnt_cnt1=255 and stays at 255.
REQ-033 reset_n pulled low in the cycle fifo_wr_en=1 -> fifo_wr_en and gnt drop without waiting for clk; after release, last_gnt=1 and the held req0 is granted.
